// File: rtl/pwd_pkg.sv
// Shared types and default constants for the pulse-width decoder.
package pwd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } pwd_state_e;

  localparam int unsigned PWD_COUNT_WIDTH   = 8;
  localparam int unsigned PWD_WORD_BITS     = 8;
  localparam int unsigned PWD_ZERO_TICKS    = 9;
  localparam int unsigned PWD_ONE_TICKS     = 18;
  localparam int unsigned PWD_TOLERANCE     = 4;
  localparam int unsigned PWD_TIMEOUT_TICKS = 200;

endpackage

// File: rtl/pwd_input_conditioner.sv
// Synchronises the serial line, optionally deglitches it (PWD_GLITCH_FILTER_EN),
// and emits registered level plus rise/fall strobes.
module pwd_input_conditioner (
  input  logic clock,
  input  logic reset_n,
  input  logic digital_in,
  output logic line_level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic       primed_q;
  logic       level_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], digital_in};
  end

`ifdef PWD_GLITCH_FILTER_EN
  logic hist_q;
  logic filt_q;

  // Level follows only after three consecutive equal samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= sync_q[1];
      if ((sync_q[0] == sync_q[1]) && (sync_q[1] == hist_q)) filt_q <= sync_q[1];
    end
  end

  assign level_c = filt_q;
`else
  assign level_c = sync_q[1];
`endif

  // Edges are only reported once a genuine low has been seen after reset,
  // so a pulse already in progress at reset release is ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_q     <= '0;
      primed_q   <= 1'b0;
      line_level <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      fill_q     <= {fill_q[0], 1'b1};
      if (fill_q[1] && !level_c && !sync_q[1]) primed_q <= 1'b1;
      line_level <= level_c;
      rise       <= primed_q & level_c & ~line_level;
      fall       <= primed_q & ~level_c & line_level;
    end
  end

endmodule

// File: rtl/pulse_width_decoder.sv
// Decodes pulse-width-modulated symbols into MSB-first words with a valid/ready
// output. Optional input deglitching via PWD_GLITCH_FILTER_EN.
module pulse_width_decoder
  import pwd_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH   = PWD_COUNT_WIDTH,
  parameter int unsigned WORD_BITS     = PWD_WORD_BITS,
  parameter int unsigned ZERO_TICKS    = PWD_ZERO_TICKS,
  parameter int unsigned ONE_TICKS     = PWD_ONE_TICKS,
  parameter int unsigned TOLERANCE     = PWD_TOLERANCE,
  parameter int unsigned TIMEOUT_TICKS = PWD_TIMEOUT_TICKS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 digital_in,
  input  logic                 word_ready,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  output logic                 bit_strobe,
  output logic                 bit_value,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIST_W    = COUNT_WIDTH + 1;
  localparam int unsigned BIT_CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_TIMEOUT = COUNT_WIDTH'(TIMEOUT_TICKS);
  localparam logic [BIT_CNT_W-1:0]   LAST_BIT    = BIT_CNT_W'(WORD_BITS - 1);

  pwd_state_e             state_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_inc_c;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [WORD_BITS-1:0]   shift_q;
  logic [WORD_BITS-1:0]   word_c;
  logic [DIST_W-1:0]      width_c, d0_c, d1_c, dmin_c;
  logic                   bit_c, sym_ok_c;
  logic                   line_level, rise, fall;

  pwd_input_conditioner u_cond (
    .clock      (clock),
    .reset_n    (reset_n),
    .digital_in (digital_in),
    .line_level (line_level),
    .rise       (rise),
    .fall       (fall)
  );

  // Nearest-nominal classification of the completed pulse; ties go to 1.
  always_comb begin
    width_c   = DIST_W'(cnt_q);
    d0_c      = (width_c >= DIST_W'(ZERO_TICKS)) ? width_c - DIST_W'(ZERO_TICKS)
                                                 : DIST_W'(ZERO_TICKS) - width_c;
    d1_c      = (width_c >= DIST_W'(ONE_TICKS))  ? width_c - DIST_W'(ONE_TICKS)
                                                 : DIST_W'(ONE_TICKS) - width_c;
    bit_c     = !(d0_c < d1_c);
    dmin_c    = bit_c ? d1_c : d0_c;
    sym_ok_c  = (dmin_c <= DIST_W'(TOLERANCE));
    word_c    = {shift_q[WORD_BITS-2:0], bit_c};
    cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      bit_strobe  <= 1'b0;
      bit_value   <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bit_strobe  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (word_valid && word_ready) word_valid <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_HIGH;
            cnt_q   <= CNT_ONE;
            busy    <= 1'b1;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            state_q <= ST_LOW;
            cnt_q   <= CNT_ONE;
            if (sym_ok_c) begin
              bit_strobe <= 1'b1;
              bit_value  <= bit_c;
              shift_q    <= word_c;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
                if (!word_valid || word_ready) begin
                  word_data  <= word_c;
                  word_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              end
            end else begin
              frame_error <= 1'b1;
              bit_cnt_q   <= '0;
              shift_q     <= '0;
            end
          end else if (line_level) begin
            if (cnt_q >= CNT_TIMEOUT) begin
              state_q     <= ST_STUCK;
              frame_error <= 1'b1;
              bit_cnt_q   <= '0;
              shift_q     <= '0;
            end else begin
              cnt_q <= cnt_inc_c;
            end
          end
        end

        ST_LOW: begin
          if (rise) begin
            state_q <= ST_HIGH;
            cnt_q   <= CNT_ONE;
          end else if (!line_level) begin
            if (cnt_q >= CNT_TIMEOUT) begin
              state_q     <= ST_IDLE;
              busy        <= 1'b0;
              frame_error <= (bit_cnt_q != '0);
              bit_cnt_q   <= '0;
              shift_q     <= '0;
            end else begin
              cnt_q <= cnt_inc_c;
            end
          end
        end

        ST_STUCK: begin
          if (fall) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Scoreboard bench for pulse_width_decoder: symbol-level reference model feeds
// an expected-event queue that a negedge monitor drains.
module tb_pulse_width_decoder;

  localparam int WB  = 8;
  localparam int ZT  = 9;
  localparam int OT  = 18;
  localparam int TOL = 4;
  localparam int TO  = 200;
`ifdef PWD_GLITCH_FILTER_EN
  localparam int LAT   = 5;
  localparam int MIN_W = 3;
`else
  localparam int LAT   = 3;
  localparam int MIN_W = 1;
`endif
  localparam int STUCK_W  = TO + 1;
  localparam int LONG_GAP = 250;

  typedef struct {
    bit            is_err;
    bit            val;
    bit            load;
    bit            ovr;
    logic [WB-1:0] data;
    int            cyc;
  } ev_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          digital_in = 1'b0;
  logic          word_ready = 1'b1;
  logic [WB-1:0] word_data;
  logic          word_valid, bit_strobe, bit_value, frame_error, overrun, busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;

  int            m_bits = 0;
  int            m_acc = 0;
  logic [WB-1:0] m_data = '0;
  bit            m_valid = 1'b0;

  pulse_width_decoder dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .digital_in  (digital_in),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .bit_strobe  (bit_strobe),
    .bit_value   (bit_value),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic push_err();
    ev_t e;
    e = '{default: 0};
    e.is_err = 1'b1;
    e.cyc    = -1;
    exp_q.push_back(e);
  endtask

  // Reference: nearest nominal width wins, ties to 1, reject beyond tolerance.
  task automatic model_pulse(input int w, input bit rdy, input int exp_cyc);
    ev_t e;
    int  d0, d1, dmin;
    e     = '{default: 0};
    e.cyc = exp_cyc;
    d0    = absd(w, ZT);
    d1    = absd(w, OT);
    dmin  = (d0 < d1) ? d0 : d1;
    if (dmin > TOL) begin
      e.is_err = 1'b1;
      m_bits   = 0;
      m_acc    = 0;
    end else begin
      e.val  = (d0 < d1) ? 1'b0 : 1'b1;
      m_acc  = m_acc * 2 + int'(e.val);
      m_bits = m_bits + 1;
      if (m_bits == WB) begin
        if (!m_valid || rdy) begin
          m_data  = WB'(m_acc);
          e.load  = 1'b1;
          m_valid = !rdy;
        end else begin
          e.ovr = 1'b1;
        end
        m_bits = 0;
        m_acc  = 0;
      end
    end
    e.data = m_data;
    exp_q.push_back(e);
  endtask

  task automatic send_pulse(input int w, input int g);
    if (w >= STUCK_W) begin
      push_err();
      m_bits = 0;
      m_acc  = 0;
    end
    digital_in = 1'b1;
    repeat (w) @(negedge clock);
    digital_in = 1'b0;
    if (w < STUCK_W) model_pulse(w, word_ready, cyc + LAT + 1);
    if (g > TO) begin
      if (m_bits != 0) push_err();
      m_bits = 0;
      m_acc  = 0;
    end
    repeat (g) @(negedge clock);
  endtask

  task automatic send_word(input logic [WB-1:0] b, input int g);
    for (int i = WB - 1; i >= 0; i--) send_pulse(b[i] ? OT : ZT, g);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    check("reset_outputs", 32'({word_data, word_valid, bit_strobe, bit_value,
                                frame_error, overrun, busy}), 32'(0));
    check("queue_empty_at_reset", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    m_bits  = 0;
    m_acc   = 0;
    m_data  = '0;
    m_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  // Monitor: every strobe or error must match the next expected event.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bit_strobe || frame_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'({bit_strobe, frame_error}), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", 32'(frame_error), 32'(mon_e.is_err));
          if (!mon_e.is_err) begin
            check("bit_value", 32'(bit_value), 32'(mon_e.val));
            check("overrun", 32'(overrun), 32'(mon_e.ovr));
            if (mon_e.load) check("word_valid_on_load", 32'(word_valid), 32'(1));
            check("word_data", 32'(word_data), 32'(mon_e.data));
          end
          if (mon_e.cyc >= 0) check("event_latency", 32'(cyc), 32'(mon_e.cyc));
        end
      end else if (overrun) begin
        check("stray_overrun", 32'(overrun), 32'(0));
      end
    end
  end

  initial begin
    int pat[8];
    int w, g, n;
    pat = '{18, 9, 18, 9, 9, 18, 9, 18};

    @(negedge clock);
    check("initial_reset_outputs", 32'({word_data, word_valid, bit_strobe, bit_value,
                                        frame_error, overrun, busy}), 32'(0));
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);

    // Canonical 0xA5 word
    foreach (pat[i]) send_pulse(pat[i], 10);
    repeat (10) @(negedge clock);
    check("a5_word", 32'(word_data), 32'(8'hA5));

    // Decision boundary and rejection, then a clean word
    send_pulse(13, 10);
    send_pulse(14, 10);
    send_pulse(25, 10);
    send_word(8'h5A, 10);

    // Gap timeout with a partial word
    send_pulse(OT, 10);
    send_pulse(ZT, 10);
    send_pulse(OT, LONG_GAP);
    check("busy_after_gap_timeout", 32'(busy), 32'(0));
    send_word(8'hC3, 10);

    // Stuck-high pulse
    send_pulse(OT, 10);
    send_pulse(230, 20);
    check("busy_after_stuck", 32'(busy), 32'(0));
    send_word(8'h69, 8);

    // Overrun with consumer stalled
    repeat (20) @(negedge clock);
    word_ready = 1'b0;
    send_word(8'h3C, 10);
    send_word(8'hE1, 10);
    repeat (10) @(negedge clock);
    check("held_valid", 32'(word_valid), 32'(1));
    check("held_data", 32'(word_data), 32'(8'h3C));

    // Completion coinciding with a handshake
    for (int i = 7; i >= 1; i--) send_pulse((8'h5B >> i) & 1 ? OT : ZT, 10);
    digital_in = 1'b1;
    repeat (OT) @(negedge clock);
    digital_in = 1'b0;
    n = cyc;
    model_pulse(OT, 1'b1, n + LAT + 1);
    m_valid = 1'b1;
    repeat (LAT) @(negedge clock);
    word_ready = 1'b1;
    @(negedge clock);
    word_ready = 1'b0;
    repeat (10) @(negedge clock);
    check("handshake_load_valid", 32'(word_valid), 32'(1));
    check("handshake_load_data", 32'(word_data), 32'(8'h5B));
    word_ready = 1'b1;
    @(negedge clock);
    check("valid_clears_after_handshake", 32'(word_valid), 32'(0));
    m_valid = 1'b0;

    // Reset after a partial word
    send_pulse(OT, 10); send_pulse(ZT, 10); send_pulse(OT, 10);
    send_pulse(OT, 10); send_pulse(ZT, 10);
    repeat (10) @(negedge clock);
    do_reset();
    send_word(8'h96, 10);
    repeat (10) @(negedge clock);
    check("word_after_reset", 32'(word_data), 32'(8'h96));

    // Reset released while the line is already high
    digital_in = 1'b1;
    repeat (5) @(negedge clock);
    do_reset();
    repeat (10) @(negedge clock);
    digital_in = 1'b0;
    repeat (20) @(negedge clock);
    send_word(8'h0F, 10);

    // Randomised symbols, gaps and aborts
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 3))
        0:       w = int'($urandom_range(ZT - TOL - 1, ZT + TOL + 1));
        1:       w = int'($urandom_range(OT - TOL - 1, OT + TOL + 1));
        2:       w = int'($urandom_range(MIN_W, 45));
        default: w = ($urandom_range(0, 1) != 0) ? ZT : OT;
      endcase
      g = int'($urandom_range(MIN_W, 25));
      if ($urandom_range(0, 29) == 0) g = LONG_GAP;
      if ($urandom_range(0, 59) == 0) w = 230;
      send_pulse(w, g);
    end

    repeat (40) @(negedge clock);
    check("all_expected_events_seen", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_width_decoder.md
PULSE_WIDTH_DECODER -- requirements
Module: pulse_width_decoder

Interface
REQ-001 Parameter COUNT_WIDTH, default 8: width of the pulse and gap counters.
REQ-002 Parameter WORD_BITS, default 8: number of bits per assembled word.
REQ-003 Parameter ZERO_TICKS, default 9: nominal high-pulse width of a 0 symbol, in clocks.
REQ-004 Parameter ONE_TICKS, default 18: nominal high-pulse width of a 1 symbol, in clocks.
REQ-005 Parameter TOLERANCE, default 4: maximum accepted distance from the nearest nominal width.
REQ-006 Parameter TIMEOUT_TICKS, default 200: gap or pulse length, in clocks, that aborts a frame.
REQ-007 clock, input, 1: the single clock; all state changes on its rising edge.
REQ-008 reset_n, input, 1: asynchronous, active-low reset.
REQ-009 digital_in, input, 1: asynchronous serial line.
REQ-010 word_ready, input, 1: consumer accepts word_data when it is high together with word_valid.
REQ-011 word_data, output, WORD_BITS: last completed word; first received bit is the MSB.
REQ-012 word_valid, output, 1: word_data holds an unconsumed word.
REQ-013 bit_strobe, output, 1: one-cycle pulse per accepted symbol.
REQ-014 bit_value, output, 1: decoded value of the symbol; valid while bit_strobe is high.
REQ-015 frame_error, output, 1: one-cycle pulse on a rejected symbol or an aborted partial word.
REQ-016 overrun, output, 1: one-cycle pulse when a completed word is dropped.
REQ-017 busy, output, 1: high whenever the state is not IDLE.

Function
REQ-018 digital_in SHALL pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised signal only.
REQ-019 States SHALL be IDLE, HIGH, LOW and STUCK.
- IDLE -> HIGH on a rising edge.
- HIGH -> LOW on a falling edge.
- LOW -> HIGH on a rising edge.
REQ-020 Pulse width w SHALL equal the number of clocks the synchronised line was high; the counter is cleared on the rising edge and saturates at 2^COUNT_WIDTH-1.
REQ-021 On the falling edge, compute d0=|w-ZERO_TICKS| and d1=|w-ONE_TICKS| unsigned, COUNT_WIDTH+1 bits, no wrap. bit_value SHALL be 0 if d0<d1, else 1 (a tie decodes as 1).
REQ-022 If min(d0,d1)>TOLERANCE, the symbol SHALL be discarded: frame_error pulses, the bit count clears, no bit_strobe.
REQ-023 Latency from the digital_in falling edge (first sampling clock) to bit_strobe SHALL be exactly 3 clocks with the filter compiled out.
REQ-024 Accepted bits SHALL shift in MSB first; on bit WORD_BITS, the word moves to word_data, word_valid sets and the bit count clears, all in the strobe cycle.
REQ-025 word_valid SHALL clear the cycle after word_valid&&word_ready.
REQ-026 If a word completes while word_valid=1 and word_ready=0, the new word SHALL be dropped, word_data kept, and overrun pulsed.
REQ-027 A word completing in the same cycle as a handshake SHALL be loaded with word_valid staying 1, without overrun.
REQ-028 In LOW, if the gap counter reaches TIMEOUT_TICKS, the state SHALL go to IDLE, the partial word is discarded, and frame_error pulses only if the bit count was nonzero.
REQ-029 In HIGH, if w reaches TIMEOUT_TICKS: go to STUCK, pulse frame_error, clear the bit count; STUCK -> IDLE on the falling edge, with no symbol.

Reset
REQ-030 While reset_n=0, all of the following SHALL be 0:
- state (IDLE), counters, bit count, shift register and synchroniser flops;
- word_data, word_valid, bit_strobe, bit_value, frame_error, overrun, busy.
REQ-031 Deassertion mid-pulse SHALL NOT produce a symbol until a full rising edge is seen.

Configuration
REQ-032 Macro PWD_GLITCH_FILTER_EN:
- Defined: the synchronised line SHALL change only after 3 consecutive equal samples, suppressing pulses of 2 clocks or less and adding 2 clocks to REQ-023.
- Undefined: the filter is absent and latency is 3.

Structure
REQ-033 Package pwd_pkg SHALL hold the state enum and the default parameter constants.
REQ-034 Sub-module pwd_input_conditioner SHALL contain the synchroniser, the optional filter and edge detection, outputting line_level, rise and fall.

Verification (defaults, filter off)
REQ-035 Eight pulses with widths 18,9,18,9,9,18,9,18, each followed by a 10-clock low gap -> 8 bit_strobes, word_data=0xA5, word_valid=1.
REQ-036 Pulse of 13 -> bit_value 0; pulse of 14 -> bit_value 1; neither produces an error.
REQ-037 Pulse of 25 (d1=7) -> frame_error pulse, no strobe, next word starts from bit 0.
REQ-038 Two words sent with word_ready=0 -> one overrun pulse, word_data still equals the first word.
REQ-039 Three bits then low for 200 clocks -> frame_error pulse, busy=0, the next 8 bits form a clean word.
REQ-040 reset_n low after 5 bits, then a full word -> outputs 0 during reset, then the correct word with no stale bits.
